// File: rtl/picoseq_pkg.sv
// Shared definitions for the picoseq microsequencer: opcodes, condition
// selectors, FSM state encoding and instruction width helpers.
package picoseq_pkg;

  localparam logic [2:0] OP_JUMP  = 3'b000;
  localparam logic [2:0] OP_WRITE = 3'b001;
  localparam logic [2:0] OP_CALL  = 3'b010;
  localparam logic [2:0] OP_RET   = 3'b011;
  localparam logic [2:0] OP_WAIT  = 3'b100;
  localparam logic [2:0] OP_SET   = 3'b101;
  localparam logic [2:0] OP_CLR   = 3'b110;
  localparam logic [2:0] OP_NOP   = 3'b111;

  localparam logic [3:0] CSEL_ZERO = 4'd0;
  localparam logic [3:0] CSEL_ONE  = 4'd15;

  typedef enum logic {
    FETCH   = 1'b0,
    EXECUTE = 1'b1
  } state_t;

  function automatic int calc_pay_w(input int addr_w, input int rsel_w, input int data_w);
    return (addr_w > rsel_w + data_w) ? addr_w : (rsel_w + data_w);
  endfunction

  function automatic int calc_instr_w(input int pay_w);
    return 8 + pay_w;
  endfunction

endpackage

// File: rtl/picoseq_stack.sv
// Return-address LIFO; push when full and pop when empty are ignored.
module picoseq_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top_data,
  output logic             full,
  output logic             empty
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] mem [DEPTH];

  assign full  = (cnt == CNT_W'(DEPTH));
  assign empty = (cnt == '0);

  // cnt is the number of valid entries, so the top lives at index cnt-1
  always_comb begin
    top_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (cnt == CNT_W'(i + 1)) top_data = mem[i];
    end
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      cnt <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && !full) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (cnt == CNT_W'(i)) mem[i] <= push_data;
      end
      cnt <= cnt + CNT_W'(1);
    end else if (pop && !empty) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

endmodule

// File: rtl/picoseq.sv
// Two-state FETCH/EXECUTE microsequencer driving N_REG output registers from
// an external instruction ROM, with conditional jumps, calls and waits.
module picoseq
  import picoseq_pkg::*;
#(
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 8,
  parameter int N_COND      = 6,
  parameter int N_REG       = 4,
  parameter int STACK_DEPTH = 4,
  localparam int RSEL_W     = $clog2(N_REG),
  localparam int PAY_W      = calc_pay_w(ADDR_W, RSEL_W, DATA_W),
  localparam int INSTR_W    = calc_instr_w(PAY_W)
) (
  input  logic                    clk,
  input  logic                    res_n,
  input  logic                    run,
  input  logic [N_COND-1:0]       cond,
  output logic [ADDR_W-1:0]       instruction_rom_addr,
  input  logic [INSTR_W-1:0]      instruction_rom_data,
  output logic [N_REG*DATA_W-1:0] reg_out,
  output logic                    waiting,
  output logic                    stack_err
);

  state_t              state, state_nxt;
  logic [ADDR_W-1:0]   pc, pc_nxt, pc_inc;
  logic [INSTR_W-1:0]  ir;
  logic [N_COND-1:0]   cond_meta, cond_sync;
  logic [DATA_W-1:0]   regs [N_REG];
  logic                wait_q;

  logic                polarity;
  logic [3:0]          cond_sel;
  logic [2:0]          opcode;
  logic [PAY_W-1:0]    payload;
  logic [RSEL_W-1:0]   reg_sel;
  logic [DATA_W-1:0]   data;
  logic [ADDR_W-1:0]   target;
  logic                sel_cond, is_true;
  logic                push, pop, stk_full, stk_empty;
  logic                err_set, reg_we, wait_stall;
  logic [ADDR_W-1:0]   stk_top;

  assign polarity = ir[INSTR_W-1];
  assign cond_sel = ir[INSTR_W-2 -: 4];
  assign opcode   = ir[PAY_W+2 -: 3];
  assign payload  = ir[PAY_W-1:0];
  assign reg_sel  = payload[RSEL_W+DATA_W-1 -: RSEL_W];
  assign data     = payload[DATA_W-1:0];
  assign target   = payload[ADDR_W-1:0];
  assign pc_inc   = pc + ADDR_W'(1);

  assign instruction_rom_addr = pc;

  // Unused selector codes between N_COND+1 and 14 fall through to 0
  always_comb begin
    sel_cond = 1'b0;
    if (cond_sel == CSEL_ZERO) begin
      sel_cond = 1'b0;
    end else if (cond_sel == CSEL_ONE) begin
      sel_cond = 1'b1;
    end else begin
      for (int i = 0; i < N_COND; i++) begin
        if (cond_sel == 4'(i + 1)) sel_cond = cond_sync[i];
      end
    end
  end

  assign is_true = (polarity == sel_cond);

  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    push       = 1'b0;
    pop        = 1'b0;
    err_set    = 1'b0;
    reg_we     = 1'b0;
    wait_stall = 1'b0;
    case (state)
      FETCH: begin
        if (run) state_nxt = EXECUTE;
      end
      EXECUTE: begin
        state_nxt = FETCH;
        pc_nxt    = pc_inc;
        case (opcode)
          OP_JUMP: if (is_true) pc_nxt = target;
          OP_WRITE, OP_SET, OP_CLR: reg_we = is_true;
          OP_CALL: begin
            if (is_true) begin
              if (stk_full) begin
                err_set = 1'b1;
              end else begin
                push   = 1'b1;
                pc_nxt = target;
              end
            end
          end
          OP_RET: begin
            if (is_true) begin
              if (stk_empty) begin
                err_set = 1'b1;
              end else begin
                pop    = 1'b1;
                pc_nxt = stk_top;
              end
            end
          end
          OP_WAIT: begin
            if (!is_true) begin
              pc_nxt     = pc;
              wait_stall = 1'b1;
            end
          end
          OP_NOP: ;
          default: ;
        endcase
      end
      default: state_nxt = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state     <= FETCH;
      pc        <= '0;
      ir        <= '0;
      wait_q    <= 1'b0;
      stack_err <= 1'b0;
      cond_meta <= '0;
      cond_sync <= '0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      cond_meta <= cond;
      cond_sync <= cond_meta;
      if (state == FETCH && run) ir <= instruction_rom_data;
      if (state == EXECUTE) wait_q <= wait_stall;
      if (err_set) stack_err <= 1'b1;
    end
  end

  // Out-of-range reg_sel matches no index, so the write silently drops
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      for (int i = 0; i < N_REG; i++) regs[i] <= '0;
    end else if (reg_we) begin
      for (int i = 0; i < N_REG; i++) begin
        if (reg_sel == RSEL_W'(i)) begin
          case (opcode)
            OP_SET:  regs[i] <= regs[i] | data;
            OP_CLR:  regs[i] <= regs[i] & ~data;
            default: regs[i] <= data;
          endcase
        end
      end
    end
  end

  genvar g;
  generate
    for (g = 0; g < N_REG; g++) begin : g_pack
      assign reg_out[g*DATA_W +: DATA_W] = regs[g];
    end
  endgenerate

  // A stalled WAIT stays visible through the refetch that follows it
  assign waiting = (state == EXECUTE) ? wait_stall : wait_q;

  picoseq_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (ADDR_W)
  ) u_stack (
    .clk       (clk),
    .res_n     (res_n),
    .push      (push),
    .pop       (pop),
    .push_data (pc_inc),
    .top_data  (stk_top),
    .full      (stk_full),
    .empty     (stk_empty)
  );

endmodule

// File: tb/tb_picoseq.sv
// Bench for picoseq: directed scenarios plus random programs checked against
// an instruction-level model of the sequencer.
module tb_picoseq;
  import picoseq_pkg::*;

  logic        clk = 1'b0;
  logic        res_n;
  logic        run;
  logic [5:0]  cond;
  logic [4:0]  rom_addr;
  logic [17:0] rom_data;
  logic [31:0] reg_out;
  logic        waiting;
  logic        stack_err;
  logic [17:0] rom [32];

  int n_cmp = 0;
  int n_bad = 0;

  // Instruction-level model state
  int          m_pc;
  logic [7:0]  m_regs [4];
  int          m_stk [$];
  bit          m_err, m_wait;
  logic [5:0]  m_cond_prev;

  assign rom_data = rom[rom_addr];
  always #5 clk = ~clk;

  picoseq dut (
    .clk                  (clk),
    .res_n                (res_n),
    .run                  (run),
    .cond                 (cond),
    .instruction_rom_addr (rom_addr),
    .instruction_rom_data (rom_data),
    .reg_out              (reg_out),
    .waiting              (waiting),
    .stack_err            (stack_err)
  );

  function automatic logic [17:0] enc(input logic pol, input logic [3:0] cs,
                                      input logic [2:0] op, input logic [9:0] pay);
    return {pol, cs, op, pay};
  endfunction

  function automatic logic [9:0] wr(input logic [1:0] rs, input logic [7:0] d);
    return {rs, d};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h required %h", tag, obs, exp);
    end
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 32; i++) rom[i] = enc(1'b1, 4'd15, OP_NOP, 10'd0);
  endtask

  task automatic model_reset();
    m_pc = 0;
    for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
    m_stk.delete();
    m_err = 0;
    m_wait = 0;
    m_cond_prev = 6'd0;
  endtask

  // Executes one instruction by the programmer's-manual rules
  task automatic model_exec(input logic [17:0] ins, input logic [5:0] cv);
    int cs, op, rs, tgt, npc;
    logic [7:0] d;
    bit sel, t;
    cs  = int'(ins[16:13]);
    op  = int'(ins[12:10]);
    rs  = int'(ins[9:8]);
    d   = ins[7:0];
    tgt = int'(ins[4:0]);
    if (cs == 15) sel = 1;
    else if (cs >= 1 && cs <= 6) sel = cv[cs-1];
    else sel = 0;
    t = (ins[17] == sel);
    npc = (m_pc + 1) % 32;
    m_wait = 0;
    case (op)
      0: if (t) npc = tgt;
      1: if (t) m_regs[rs] = d;
      2: if (t) begin
           if (m_stk.size() == 4) m_err = 1;
           else begin m_stk.push_back((m_pc + 1) % 32); npc = tgt; end
         end
      3: if (t) begin
           if (m_stk.size() == 0) m_err = 1;
           else npc = m_stk.pop_back();
         end
      4: if (!t) begin npc = m_pc; m_wait = 1; end
      5: if (t) m_regs[rs] = m_regs[rs] | d;
      6: if (t) m_regs[rs] = m_regs[rs] & ~d;
      default: ;
    endcase
    m_pc = npc;
  endtask

  task automatic compare_model(input string tag);
    check({tag, ".pc"}, 32'(rom_addr), 32'(m_pc));
    check({tag, ".regs"}, reg_out, {m_regs[3], m_regs[2], m_regs[1], m_regs[0]});
    check({tag, ".err"}, 32'(stack_err), 32'(m_err));
    check({tag, ".wait"}, 32'(waiting), 32'(m_wait));
  endtask

  task automatic do_reset(input logic run_val);
    res_n = 1'b0;
    run   = run_val;
    cond  = 6'd0;
    @(negedge clk);
    @(negedge clk);
    res_n = 1'b1;
    model_reset();
  endtask

  // One full instruction (fetch + execute edge), compared afterwards;
  // a cond change here reaches the instruction after the current one
  task automatic step(input string tag, input logic [5:0] nc);
    logic [17:0] ins;
    cond = nc;
    ins  = rom[m_pc];
    @(posedge clk);
    @(posedge clk);
    #1;
    model_exec(ins, m_cond_prev);
    m_cond_prev = nc;
    compare_model(tag);
  endtask

  initial begin
    res_n = 1'b0;
    run   = 1'b0;
    cond  = 6'd0;
    clear_rom();

    // Reset values
    #12;
    check("rst.pc", 32'(rom_addr), 32'd0);
    check("rst.regs", reg_out, 32'd0);
    check("rst.wait", 32'(waiting), 32'd0);
    check("rst.err", 32'(stack_err), 32'd0);

    // First instruction: WRITE reg2 = 0xA5
    clear_rom();
    rom[0] = enc(1'b1, 4'd15, OP_WRITE, wr(2'd2, 8'hA5));
    do_reset(1'b1);
    step("wr1", 6'd0);
    check("wr1.reg2", 32'(reg_out[23:16]), 32'hA5);
    check("wr1.pc", 32'(rom_addr), 32'd1);

    // CALL / SET / RET / WRITE
    clear_rom();
    rom[0] = enc(1'b1, 4'd15, OP_CALL, 10'd8);
    rom[1] = enc(1'b1, 4'd15, OP_WRITE, wr(2'd0, 8'h11));
    rom[8] = enc(1'b1, 4'd15, OP_SET, wr(2'd1, 8'h0F));
    rom[9] = enc(1'b1, 4'd15, OP_RET, 10'd0);
    do_reset(1'b1);
    step("call", 6'd0);
    check("call.pc", 32'(rom_addr), 32'd8);
    step("set", 6'd0);
    check("set.reg1", 32'(reg_out[15:8]), 32'h0F);
    step("ret", 6'd0);
    check("ret.pc", 32'(rom_addr), 32'd1);
    check("ret.depth", 32'(m_stk.size()), 32'd0);
    step("wr0", 6'd0);
    check("wr0.reg0", 32'(reg_out[7:0]), 32'h11);

    // Stack overflow on the fifth nested CALL, sticky error
    clear_rom();
    for (int i = 0; i < 5; i++) rom[i] = enc(1'b1, 4'd15, OP_CALL, 10'(i + 1));
    do_reset(1'b1);
    for (int i = 0; i < 4; i++) step("nest", 6'd0);
    check("nest.err_clear", 32'(stack_err), 32'd0);
    step("ovf", 6'd0);
    check("ovf.pc", 32'(rom_addr), 32'd5);
    check("ovf.err", 32'(stack_err), 32'd1);
    for (int i = 0; i < 3; i++) step("ovf_hold", 6'd0);
    check("ovf.sticky", 32'(stack_err), 32'd1);

    // Underflow on RET from an empty stack
    clear_rom();
    rom[0] = enc(1'b1, 4'd15, OP_RET, 10'd0);
    do_reset(1'b1);
    check("unf.err_rst", 32'(stack_err), 32'd0);
    step("unf", 6'd0);
    check("unf.pc", 32'(rom_addr), 32'd1);
    check("unf.err", 32'(stack_err), 32'd1);

    // WAIT on cond[2] high
    clear_rom();
    rom[0] = enc(1'b1, 4'd3, OP_WAIT, 10'd0);
    do_reset(1'b1);
    for (int i = 0; i < 3; i++) step("wait_lo", 6'd0);
    check("wait_lo.pc", 32'(rom_addr), 32'd0);
    check("wait_lo.wait", 32'(waiting), 32'd1);
    @(posedge clk);
    #1;
    check("wait_exec.wait", 32'(waiting), 32'd1);
    @(posedge clk);
    #1;
    step("wait_rise", 6'b000100);
    check("wait_rise.pc", 32'(rom_addr), 32'd0);
    step("wait_go", 6'b000100);
    check("wait_go.pc", 32'(rom_addr), 32'd1);
    check("wait_go.wait", 32'(waiting), 32'd0);

    // run held low, then dropped during an EXECUTE
    clear_rom();
    rom[0] = enc(1'b1, 4'd15, OP_WRITE, wr(2'd3, 8'h5A));
    rom[1] = enc(1'b1, 4'd15, OP_WRITE, wr(2'd0, 8'h77));
    do_reset(1'b0);
    repeat (10) @(negedge clk);
    check("idle.pc", 32'(rom_addr), 32'd0);
    check("idle.regs", reg_out, 32'd0);
    run = 1'b1;
    @(posedge clk);
    #1;
    run = 1'b0;
    @(posedge clk);
    #1;
    check("rundrop.reg3", 32'(reg_out[31:24]), 32'h5A);
    check("rundrop.pc", 32'(rom_addr), 32'd1);
    repeat (6) @(negedge clk);
    check("stall.pc", 32'(rom_addr), 32'd1);
    check("stall.reg0", 32'(reg_out[7:0]), 32'h00);

    // Never-taken JUMP at the top address wraps the PC
    clear_rom();
    rom[0]  = enc(1'b1, 4'd15, OP_JUMP, 10'd31);
    rom[31] = enc(1'b1, 4'd0, OP_JUMP, 10'd5);
    do_reset(1'b1);
    step("jmp31", 6'd0);
    check("jmp31.pc", 32'(rom_addr), 32'd31);
    step("wrap", 6'd0);
    check("wrap.pc", 32'(rom_addr), 32'd0);

    // Reset asserted mid-EXECUTE of a WRITE
    clear_rom();
    rom[0] = enc(1'b1, 4'd15, OP_WRITE, wr(2'd1, 8'hFF));
    do_reset(1'b1);
    @(posedge clk);
    #2;
    res_n = 1'b0;
    #1;
    check("midrst.regs", reg_out, 32'd0);
    check("midrst.pc", 32'(rom_addr), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("midrst.hold", reg_out, 32'd0);

    // Random programs with changing conditions
    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 32; i++) begin
        rom[i] = enc(1'($urandom), 4'($urandom_range(0, 15)),
                     3'($urandom_range(0, 7)), 10'($urandom));
      end
      do_reset(1'b1);
      for (int s = 0; s < 150; s++) step("rand", 6'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
